// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions.
//   - ALU function encodings (alu_fun_e)
//   - ALU B-operand source codes (srcb_e)
//   - register-0 constant (REG_ZERO)
//   - registered ID/EX state record (ex_reg_t)
//   - imm_operand(): B-operand select for the immediate forms
package mips_pkg;

   typedef enum logic [5:0] {
      ALU_ADD = 6'b000000,
      ALU_SUB = 6'b000001,
      ALU_AND = 6'b011000,
      ALU_OR  = 6'b011110,
      ALU_XOR = 6'b010110,
      ALU_NOR = 6'b010001,
      ALU_A   = 6'b011010,
      ALU_SLL = 6'b100000,
      ALU_SRL = 6'b100001,
      ALU_SRA = 6'b100011,
      ALU_EQ  = 6'b110011,
      ALU_NEQ = 6'b110001,
      ALU_LT  = 6'b110101,
      ALU_LEZ = 6'b111101,
      ALU_GEZ = 6'b111001,
      ALU_GTZ = 6'b111111
   } alu_fun_e;

   typedef enum logic [1:0] {
      SRCB_RT   = 2'b00,   // forwarded rt
      SRCB_SEXT = 2'b01,   // sign-extended imm16
      SRCB_ZEXT = 2'b10,   // zero-extended imm16
      SRCB_LUI  = 2'b11    // {imm16, 16'b0}
   } srcb_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [15:0] imm16;
      logic [4:0]  shamt;
      logic [5:0]  alu_fun;
      logic        sign;
      logic        alusrc_a;
      srcb_e       alusrc_b;
      logic [4:0]  rd;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
   } ex_reg_t;

   // B operand: rt for register forms, otherwise one of the imm16 expansions.
   function automatic logic [31:0] imm_operand(input srcb_e sel, input logic [15:0] imm,
                                               input logic [31:0] rt);
      case (sel)
         SRCB_SEXT: return {{16{imm[15]}}, imm};
         SRCB_ZEXT: return {16'h0000, imm};
         SRCB_LUI:  return {imm, 16'h0000};
         default:   return rt;
      endcase
   endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: all non-clock signals of the ID/EX operand stage.
//   master : upstream/downstream pipeline (drives id_*, flush, exm_*, wb_*)
//   slave  : ex_operand_stage (drives stall and the EX/ALU outputs)
interface ex_operand_stage_if;
   // ID side
   logic        id_valid;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm16;
   logic [4:0]  id_shamt;
   logic [5:0]  id_alu_fun;
   logic        id_sign, id_alusrc_a;
   logic [1:0]  id_alusrc_b;
   logic        id_mem_read, id_mem_write, id_reg_write;
   logic        flush;
   // writeback candidates
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   // stage outputs
   logic        stall, ex_valid;
   logic [31:0] alu_a, alu_b;
   logic [5:0]  alu_fun;
   logic        alu_sign;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_mem_read, ex_mem_write, ex_reg_write;

   modport master (
      output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
             id_imm16, id_shamt, id_alu_fun, id_sign, id_alusrc_a, id_alusrc_b,
             id_mem_read, id_mem_write, id_reg_write, flush,
             exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
      input  stall, ex_valid, alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_rd,
             ex_mem_read, ex_mem_write, ex_reg_write
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
             id_imm16, id_shamt, id_alu_fun, id_sign, id_alusrc_a, id_alusrc_b,
             id_mem_read, id_mem_write, id_reg_write, flush,
             exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
      output stall, ex_valid, alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_rd,
             ex_mem_read, ex_mem_write, ex_reg_write
   );
endinterface

// File: rtl/fwd_mux.sv
// fwd_mux: 3:1 priority operand forwarder.
//   i_addr      source register number held in EX
//   i_reg_data  register-file value captured at ID
//   i_exm_*     EX/MEM writeback candidate (highest priority)
//   i_wb_*      MEM/WB writeback candidate
//   o_data      forwarded operand
module fwd_mux
   import mips_pkg::*;
(
   input  logic [4:0]  i_addr,
   input  logic [31:0] i_reg_data,
   input  logic        i_exm_we,
   input  logic [4:0]  i_exm_rd,
   input  logic [31:0] i_exm_data,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_rd,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_data
);
   logic w_hit_exm, w_hit_wb;

   // $0 is hard-wired: a pending write to it must never be seen.
   assign w_hit_exm = i_exm_we & (i_exm_rd != REG_ZERO) & (i_exm_rd == i_addr);
   assign w_hit_wb  = i_wb_we  & (i_wb_rd  != REG_ZERO) & (i_wb_rd  == i_addr);

   always_comb begin
      o_data = i_reg_data;
      if (w_hit_exm)     o_data = i_exm_data;   // youngest producer wins
      else if (w_hit_wb) o_data = i_wb_data;
   end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register feeding the ALU.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ex_operand_stage_if.slave -- ID inputs, flush, EX/MEM and
//                MEM/WB writeback candidates in; stall, ALU operands and
//                registered EX control out.
// Resolves RAW hazards by forwarding, stalls one cycle on load-use, and
// loads a bubble on stall or flush.
module ex_operand_stage
   import mips_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   ex_operand_stage_if.slave bus
);
   ex_reg_t     r_ex;
   logic        w_stall;
   logic        w_src_hit;
   logic [31:0] w_fwd_rs, w_fwd_rt;

   // Conservative: compares both sources even when one is unused by the op.
   assign w_src_hit = (bus.id_rs_addr == r_ex.rd) | (bus.id_rt_addr == r_ex.rd);
   assign w_stall   = r_ex.valid & r_ex.mem_read & (r_ex.rd != REG_ZERO) &
                      bus.id_valid & w_src_hit & ~bus.flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex <= '0;
      end else if (bus.flush || w_stall) begin
         r_ex <= '0;   // bubble
      end else begin
         r_ex <= '{valid:     bus.id_valid,
                   rs_addr:   bus.id_rs_addr,
                   rt_addr:   bus.id_rt_addr,
                   rs_data:   bus.id_rs_data,
                   rt_data:   bus.id_rt_data,
                   imm16:     bus.id_imm16,
                   shamt:     bus.id_shamt,
                   alu_fun:   bus.id_alu_fun,
                   sign:      bus.id_sign,
                   alusrc_a:  bus.id_alusrc_a,
                   alusrc_b:  srcb_e'(bus.id_alusrc_b),
                   rd:        bus.id_rd_addr,
                   mem_read:  bus.id_mem_read,
                   mem_write: bus.id_mem_write,
                   reg_write: bus.id_reg_write};
      end
   end

   fwd_mux u_fwd_rs (
      .i_addr     (r_ex.rs_addr),
      .i_reg_data (r_ex.rs_data),
      .i_exm_we   (bus.exm_reg_write),
      .i_exm_rd   (bus.exm_rd),
      .i_exm_data (bus.exm_result),
      .i_wb_we    (bus.wb_reg_write),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_result),
      .o_data     (w_fwd_rs)
   );

   fwd_mux u_fwd_rt (
      .i_addr     (r_ex.rt_addr),
      .i_reg_data (r_ex.rt_data),
      .i_exm_we   (bus.exm_reg_write),
      .i_exm_rd   (bus.exm_rd),
      .i_exm_data (bus.exm_result),
      .i_wb_we    (bus.wb_reg_write),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_result),
      .o_data     (w_fwd_rt)
   );

   assign bus.stall         = w_stall;
   assign bus.ex_valid      = r_ex.valid;
   assign bus.alu_a         = r_ex.alusrc_a ? {27'b0, r_ex.shamt} : w_fwd_rs;
   assign bus.alu_b         = imm_operand(r_ex.alusrc_b, r_ex.imm16, w_fwd_rt);
   assign bus.alu_fun       = r_ex.alu_fun;
   assign bus.alu_sign      = r_ex.sign;
   assign bus.ex_store_data = w_fwd_rt;
   assign bus.ex_rd         = r_ex.rd;
   assign bus.ex_mem_read   = r_ex.mem_read;
   assign bus.ex_mem_write  = r_ex.mem_write;
   assign bus.ex_reg_write  = r_ex.reg_write;
endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ex_operand_stage_if bus ();
   ex_operand_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // reference: instruction currently held in EX (zero = bubble)
   logic        m_valid, m_sign, m_sa, m_mr, m_mw, m_rw;
   logic [4:0]  m_rs, m_rt, m_rd, m_sh;
   logic [31:0] m_rsd, m_rtd;
   logic [15:0] m_imm;
   logic [5:0]  m_fun;
   logic [1:0]  m_sb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
      if (bus.exm_reg_write && bus.exm_rd != 0 && bus.exm_rd == a) return bus.exm_result;
      if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == a) return bus.wb_result;
      return d;
   endfunction

   function automatic logic ref_stall();
      return m_valid && m_mr && m_rd != 0 && bus.id_valid && !bus.flush &&
             (bus.id_rs_addr == m_rd || bus.id_rt_addr == m_rd);
   endfunction

   function automatic logic [31:0] ref_b();
      int s;
      s = $signed(m_imm);
      if (m_sb == 2'd1) return 32'(s);
      if (m_sb == 2'd2) return 32'(m_imm);
      if (m_sb == 2'd3) return 32'(m_imm) * 32'h0001_0000;
      return ref_fwd(m_rt, m_rtd);
   endfunction

   task automatic model_reset();
      {m_valid, m_sign, m_sa, m_mr, m_mw, m_rw} = '0;
      {m_rs, m_rt, m_rd, m_sh, m_rsd, m_rtd, m_imm, m_fun, m_sb} = '0;
   endtask

   // check all outputs against the model, then advance one clock
   task automatic tick(input string tag);
      logic st;
      #1;
      st = ref_stall();
      chk({tag, ".stall"},  32'(bus.stall), 32'(st));
      chk({tag, ".valid"},  32'(bus.ex_valid), 32'(m_valid));
      chk({tag, ".alu_a"},  bus.alu_a, m_sa ? 32'(m_sh) : ref_fwd(m_rs, m_rsd));
      chk({tag, ".alu_b"},  bus.alu_b, ref_b());
      chk({tag, ".fun"},    32'(bus.alu_fun), 32'(m_fun));
      chk({tag, ".sign"},   32'(bus.alu_sign), 32'(m_sign));
      chk({tag, ".store"},  bus.ex_store_data, ref_fwd(m_rt, m_rtd));
      chk({tag, ".rd"},     32'(bus.ex_rd), 32'(m_rd));
      chk({tag, ".ctl"},    32'({bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write}),
                            32'({m_mr, m_mw, m_rw}));
      if (!rst_n || bus.flush || st) model_reset();
      else begin
         m_valid = bus.id_valid;   m_rs = bus.id_rs_addr;   m_rt = bus.id_rt_addr;
         m_rsd = bus.id_rs_data;   m_rtd = bus.id_rt_data;  m_imm = bus.id_imm16;
         m_sh = bus.id_shamt;      m_fun = bus.id_alu_fun;  m_sign = bus.id_sign;
         m_sa = bus.id_alusrc_a;   m_sb = bus.id_alusrc_b;  m_rd = bus.id_rd_addr;
         m_mr = bus.id_mem_read;   m_mw = bus.id_mem_write; m_rw = bus.id_reg_write;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      rst_n = 1'b1;
      bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
      bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm16 = 0; bus.id_shamt = 0;
      bus.id_alu_fun = 0; bus.id_sign = 0; bus.id_alusrc_a = 0; bus.id_alusrc_b = 0;
      bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_reg_write = 0; bus.flush = 0;
      bus.exm_reg_write = 0; bus.exm_rd = 0; bus.exm_result = 0;
      bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
   endtask

   task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] fun, input logic mr, input logic rw);
      bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_rd_addr = rd;
      bus.id_alu_fun = fun; bus.id_mem_read = mr; bus.id_reg_write = rw;
   endtask

   initial begin
      model_reset();
      idle();
      // reset
      rst_n = 0;
      tick("rst");
      tick("rst2");
      rst_n = 1;
      chk("rst.alu_a", bus.alu_a, 32'h0);
      chk("rst.stall", 32'(bus.stall), 32'h0);

      // back-to-back EX/MEM forward
      issue(5'd5, 5'd6, 5'd1, 6'b000000, 0, 1);
      tick("add1");
      idle();
      bus.exm_reg_write = 1; bus.exm_rd = 5; bus.exm_result = 32'h0000_0010;
      #1 chk("fwd_exm.alu_a", bus.alu_a, 32'h0000_0010);
      tick("add2");

      // register-0 guard
      idle();
      issue(5'd0, 5'd0, 5'd2, 6'b000000, 0, 1);
      tick("r0a");
      idle();
      bus.exm_reg_write = 1; bus.exm_rd = 0; bus.exm_result = 32'hFFFF_FFFF;
      bus.wb_reg_write = 1;  bus.wb_rd = 0;  bus.wb_result = 32'hFFFF_FFFF;
      #1 chk("r0.alu_a", bus.alu_a, 32'h0);
      tick("r0b");

      // EX/MEM beats MEM/WB
      idle();
      issue(5'd3, 5'd7, 5'd2, 6'b000000, 0, 1);
      bus.id_rt_data = 32'h55;
      tick("tie_a");
      idle();
      bus.exm_reg_write = 1; bus.exm_rd = 7; bus.exm_result = 32'h1;
      bus.wb_reg_write = 1;  bus.wb_rd = 7;  bus.wb_result = 32'h2;
      #1 chk("tie.alu_b", bus.alu_b, 32'h1);
      tick("tie_b");

      // load-use
      idle();
      issue(5'd4, 5'd0, 5'd8, 6'b000000, 1, 1);
      tick("lw");
      idle();
      issue(5'd1, 5'd8, 5'd9, 6'b000000, 0, 1);
      #1 chk("lu.stall", 32'(bus.stall), 32'h1);
      tick("lu1");
      chk("lu.bubble", 32'(bus.ex_valid), 32'h0);
      chk("lu.stall_drop", 32'(bus.stall), 32'h0);
      tick("lu2");
      idle();
      bus.wb_reg_write = 1; bus.wb_rd = 8; bus.wb_result = 32'hDEAD_BEEF;
      #1 chk("lu.alu_b", bus.alu_b, 32'hDEAD_BEEF);
      tick("lu3");

      // immediates
      for (int s = 1; s < 4; s++) begin
         idle();
         issue(5'd1, 5'd2, 5'd3, 6'b000000, 0, 1);
         bus.id_imm16 = 16'h8001; bus.id_alusrc_b = 2'(s);
         tick("imm_ld");
         idle();
         #1;
         case (s)
            1: chk("imm.sext", bus.alu_b, 32'hFFFF_8001);
            2: chk("imm.zext", bus.alu_b, 32'h0000_8001);
            default: chk("imm.lui", bus.alu_b, 32'h8001_0000);
         endcase
         tick("imm");
      end

      // SLL shamt
      idle();
      issue(5'd0, 5'd2, 5'd3, 6'b100000, 0, 1);
      bus.id_shamt = 5'd31; bus.id_alusrc_a = 1;
      tick("sll_ld");
      idle();
      #1 chk("sll.alu_a", bus.alu_a, 32'h0000_001F);
      chk("sll.fun", 32'(bus.alu_fun), 32'b100000);
      tick("sll");

      // flush with load-use
      idle();
      issue(5'd4, 5'd0, 5'd9, 6'b000000, 1, 1);
      tick("fl_lw");
      idle();
      issue(5'd9, 5'd1, 5'd2, 6'b000000, 0, 1);
      bus.flush = 1;
      #1 chk("fl.stall", 32'(bus.stall), 32'h0);
      tick("fl");
      chk("fl.valid", 32'(bus.ex_valid), 32'h0);
      chk("fl.rw", 32'(bus.ex_reg_write), 32'h0);

      // reset mid-stall
      idle();
      issue(5'd4, 5'd0, 5'd10, 6'b000000, 1, 1);
      bus.id_rs_data = 32'h1234; bus.id_sign = 1;
      tick("rs_lw");
      idle();
      issue(5'd10, 5'd10, 5'd2, 6'b000000, 0, 1);
      #1 chk("rs.stall_pre", 32'(bus.stall), 32'h1);
      rst_n = 0;
      tick("rs");
      chk("rs.stall", 32'(bus.stall), 32'h0);
      chk("rs.rd", 32'(bus.ex_rd), 32'h0);
      chk("rs.sign", 32'(bus.alu_sign), 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         bus.id_valid = $urandom_range(0, 3) != 0;
         bus.id_rs_addr = 5'($urandom_range(0, 3));
         bus.id_rt_addr = 5'($urandom_range(0, 3));
         bus.id_rd_addr = 5'($urandom_range(0, 3));
         bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
         bus.id_imm16 = 16'($urandom); bus.id_shamt = 5'($urandom);
         bus.id_alu_fun = 6'($urandom); bus.id_sign = 1'($urandom);
         bus.id_alusrc_a = 1'($urandom); bus.id_alusrc_b = 2'($urandom);
         bus.id_mem_read = $urandom_range(0, 2) == 0;
         bus.id_mem_write = 1'($urandom); bus.id_reg_write = 1'($urandom);
         bus.flush = $urandom_range(0, 7) == 0;
         bus.exm_reg_write = 1'($urandom); bus.exm_rd = 5'($urandom_range(0, 3));
         bus.exm_result = $urandom;
         bus.wb_reg_write = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3));
         bus.wb_result = $urandom;
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage for the 5-stage MIPS pipeline, sitting directly upstream of the ALU. It registers decoded operands and control once per cycle. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, detects load-use hazards and raises a stall, and inserts bubbles on stall or branch flush. It drives the ALU's `A`, `B`, `Sign` and `ALUFun` directly.

## Interface
- No parameters; data width fixed at 32, register address width fixed at 5.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_addr`, `id_rt_addr` in 5: source register numbers.
- `id_rd_addr` in 5: destination register number.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm16` in 16: immediate field.
- `id_shamt` in 5: shift amount.
- `id_alu_fun` in 6: ALU function code.
- `id_sign` in 1: signed compare/overflow.
- `id_alusrc_a` in 1: 0 = rs, 1 = zero-extended shamt.
- `id_alusrc_b` in 2: 00 = rt, 01 = sign-extended imm, 10 = zero-extended imm, 11 = {imm,16'b0}.
- `id_mem_read`, `id_mem_write`, `id_reg_write` in 1: control bits.
- `flush` in 1: branch/jump taken; kill the ID instruction.
- `exm_reg_write` in 1, `exm_rd` in 5, `exm_result` in 32: EX/MEM writeback candidate.
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_result` in 32: MEM/WB writeback candidate.
- `stall` out 1: combinational; holds PC and IF/ID.
- `ex_valid` out 1: EX holds a real instruction.
- `alu_a`, `alu_b` out 32: ALU operands after forwarding and source select.
- `alu_fun` out 6: ALU function code.
- `alu_sign` out 1: signed flag.
- `ex_store_data` out 32: forwarded rt for stores.
- `ex_rd` out 5: destination register number.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write` out 1: registered control.

## Operation
- Register state: valid, rs/rt addresses and data, imm16, shamt, alu_fun, sign, alusrc_a/b, rd, mem_read, mem_write, reg_write.
- Per-edge priority: `!rst_n` > `flush` > `stall` > load.
  - Reset clears all state to 0.
  - `flush` or `stall` loads a bubble: valid = 0, all write/mem controls 0, data don't-care (held at 0).
  - Otherwise all `id_*` inputs are loaded.
- Load-use detect (combinational): `stall` = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (id_rs_addr==ex_rd | id_rt_addr==ex_rd).
  - Compares against both sources regardless of alusrc; conservative by decision.
  - `flush` suppresses `stall`: `stall` is forced 0 whenever `flush`=1.
- Forwarding is combinational on the registered rs/rt, applied independently per operand:
  - Select `exm_result` if exm_reg_write & exm_rd≠0 & exm_rd==addr.
  - Else select `wb_result` if wb_reg_write & wb_rd≠0 & wb_rd==addr.
  - Else use the registered data.
  - EX/MEM beats MEM/WB on a tie. Register 0 is never forwarded.
- `alu_a` = alusrc_a ? {27'b0, shamt} : fwd_rs.
- `alu_b` = per the alusrc_b code, using fwd_rt for 00.
- `ex_store_data` = fwd_rt.
- Sign extension replicates imm16[15] into bits 31:16.

## Timing
- One-cycle latency from ID inputs to registered outputs.
- Forwarding adds no cycles: `alu_a`/`alu_b` are valid in the same cycle as the `exm_*`/`wb_*` inputs.
- A load-use stall lasts exactly one cycle. The next cycle EX holds a bubble, so `stall` drops and the load result is forwarded from MEM/WB.
- Reset values of all outputs: 0. This includes `stall`, since ex_valid = 0.
- `rst_n` asserted mid-stall clears the stage; `stall` is 0 on the following cycle.
- `flush` and `stall` in the same cycle: a bubble is loaded and `stall` = 0.

## Structure
- Shared package `mips_pkg`:
  - ALUFun encodings: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
  - alusrc_b codes.
  - Register-0 constant.
- One sub-module `fwd_mux`: 3:1 priority forwarder, instantiated twice (rs, rt).

## Test plan
- Back-to-back ADD, with `exm_rd`=5 writing 0x0000_0010 and the EX instruction reading rs=5 (regfile gives 0x0) → `alu_a`=0x0000_0010.
- Register-0 guard and tie priority:
  - EX/MEM and MEM/WB both targeting rd=0 with results 0xFFFF_FFFF, rs=0 → `alu_a`=0.
  - Both targeting rt=7 (exm 0x1, wb 0x2) → `alu_b`=0x1.
- Load-use: EX holds LW rd=8, ID reads rt=8 → `stall`=1 for one cycle, next `ex_valid`=0; then `wb_result`=0xDEAD_BEEF forwarded → `alu_b`=0xDEAD_BEEF.
- Immediates with imm16=0x8001:
  - alusrc_b=01 → 0xFFFF_8001.
  - alusrc_b=10 → 0x0000_8001.
  - alusrc_b=11 → 0x8001_0000.
- SLL with shamt=31 and alusrc_a=1 → `alu_a`=0x0000_001F, `alu_fun`=100000.
- `flush` asserted together with a load-use condition → `stall`=0, `ex_valid`=0 and `ex_reg_write`=0 next cycle. `rst_n`=0 mid-stream → all outputs 0 next edge.
